multicycle_mem_control_unit: RTL
================================

Name: multicycle_mem_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction instead of decoding the opcode combinationally.
- Drives datapath strobes and a ready-handshake memory port with byte/half/word sizing.
- Provides a parametrised memory wait-state timeout.
- Sits between the instruction register opcode field and the multi-cycle datapath/memory.

Parameters:
- OPCODE_W, 6, opcode field width.
- WAIT_MAX, 15, max cycles a memory access may wait for mem_ready; 0 disables the timeout.
- CNT_W, $clog2(WAIT_MAX+1) (min 1), wait-counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  OPCODE_W  instruction opcode from IR.
- mem_ready  in  1  memory completes the current access this cycle.
- addr_lo  in  2  low effective-address bits; used only with UNALIGNED_TRAP_EN.
- pc_write  out  1  PC update strobe.
- ir_write  out  1  IR load strobe.
- reg_write  out  1  register file write.
- alu_src  out  1  1 = immediate operand.
- mem_to_reg  out  2  00 ALU, 01 memory data, 10 LUI immediate.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_size  out  2  00 byte, 01 half, 10 word.
- load_signed  out  1  sign-extend loaded data.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- timeout  out  1  one-cycle pulse on memory wait overflow.
- trap  out  1  high while in TRAP (macro only; tied 0 otherwise).

Behaviour:
- Reset: asynchronous. State goes to FETCH, op_q=0, wait counter=0. While reset is high, every output is 0 and state reads 0.
- Supported opcodes:
  - R-type 0x00.
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - lui 0x0F.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
- FETCH:
  - mem_read=1, mem_size=10.
  - Holds until mem_ready=1. In the mem_ready cycle: ir_write=1, pc_write=1, next state DECODE.
- DECODE (1 cycle):
  - Latches opcode into op_q.
  - Unsupported opcode: illegal_op=1 this cycle, next state FETCH, no other strobe.
  - Otherwise next state EXEC.
- EXEC (1 cycle):
  - alu_src=1 for every supported opcode except 0x00.
  - R-type and lui go to WB; loads and stores go to MEM.
- MEM:
  - Loads assert mem_read; stores assert mem_write.
  - mem_size: byte for lb/lbu/sb, half for lh/lhu/sh, word for lw/sw.
  - load_signed=1 for lb/lh only.
  - Held constant until mem_ready=1, then loads go to WB and stores go to FETCH.
- WB (1 cycle):
  - reg_write=1.
  - mem_to_reg = 01 for loads, 10 for lui, 00 for R-type.
  - Next state FETCH.
- Wait counter:
  - Clears on entry to FETCH/MEM.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If WAIT_MAX>0, counter==WAIT_MAX and mem_ready=0: timeout=1 for that cycle, access dropped (no ir_write, pc_write or reg_write), next state FETCH.
  - mem_ready=1 in the same cycle as counter==WAIT_MAX: ready wins, no timeout.
- mem_read and mem_write are never asserted together.
- Every strobe is a decode of (state, op_q). Strobes are glitch-free relative to clk; no combinational path from opcode to outputs outside DECODE.
- Reset mid-access: outputs drop to 0 immediately and the in-flight access is abandoned.

Optional Feature:
- UNALIGNED_TRAP_EN defined: on EXEC→MEM, a misaligned access goes to TRAP instead of MEM.
  - Half access is misaligned when addr_lo[0]=1; word access when addr_lo≠00.
  - TRAP asserts trap=1 and no memory strobe. It is left only by reset.
- UNALIGNED_TRAP_EN undefined: addr_lo is ignored, trap is tied 0, state 5 is unreachable.

Test Plan:
- lw (0x23), mem_ready low 2 cycles in MEM → states 0,1,2,3,3,3,4,0; mem_read 3 cycles in MEM, mem_size=10; WB reg_write=1, mem_to_reg=01.
- sb (0x28) → MEM has mem_write=1, mem_size=00, mem_read=0; next state FETCH; reg_write never high.
- lui (0x0F) → EXEC alu_src=1, WB mem_to_reg=10, state never 3. lh (0x21) → load_signed=1; lhu (0x25) → load_signed=0, both mem_size=01.
- Opcode 0x3F → illegal_op pulse in DECODE, state 1→0, no reg_write/mem strobes.
- WAIT_MAX=3, lw with mem_ready held 0 → timeout pulse on 4th MEM cycle, then FETCH. Repeat with mem_ready=1 on that cycle → no timeout, WB. Reset asserted in MEM → all outputs 0 asynchronously, state 0.
- With UNALIGNED_TRAP_EN: sh (0x29), addr_lo=01 → state 5, trap=1, mem_write=0. addr_lo=10 → normal MEM.

Source files
------------

// File: rtl/multicycle_mem_control_unit.sv
// multicycle_mem_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with ready-handshake memory, sized accesses, wait timeout; define UNALIGNED_TRAP_EN to trap misaligned accesses
module multicycle_mem_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic [1:0]          addr_lo,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic [1:0]          mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_size,
  output logic                load_signed,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic                timeout,
  output logic                trap
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_LUI = OPCODE_W'(6'h0F);
  localparam logic [OPCODE_W-1:0] OP_LB  = OPCODE_W'(6'h20);
  localparam logic [OPCODE_W-1:0] OP_LH  = OPCODE_W'(6'h21);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_LBU = OPCODE_W'(6'h24);
  localparam logic [OPCODE_W-1:0] OP_LHU = OPCODE_W'(6'h25);
  localparam logic [OPCODE_W-1:0] OP_SB  = OPCODE_W'(6'h28);
  localparam logic [OPCODE_W-1:0] OP_SH  = OPCODE_W'(6'h29);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'h2B);
  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                legal, is_r, is_lui, is_load, is_store, is_signed, wait_hit, misaligned, trap_en;
  logic [1:0]          mem_sz;
  assign legal     = opcode inside {OP_R, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  assign is_r      = op_q == OP_R;
  assign is_lui    = op_q == OP_LUI;
  assign is_load   = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store  = op_q inside {OP_SB, OP_SH, OP_SW};
  assign is_signed = op_q inside {OP_LB, OP_LH};
  assign mem_sz    = (op_q inside {OP_LH, OP_LHU, OP_SH}) ? 2'b01 : (op_q inside {OP_LW, OP_SW}) ? 2'b10 : 2'b00;
  assign wait_hit  = (WAIT_MAX > 0) && (cnt_q == CNT_W'(WAIT_MAX)) && !mem_ready;
`ifdef UNALIGNED_TRAP_EN
  assign trap_en    = 1'b1;
  assign misaligned = (mem_sz == 2'b01 && addr_lo[0]) || (mem_sz == 2'b10 && addr_lo != 2'b00);
`else
  logic unused_addr;
  assign unused_addr = ^addr_lo;
  assign trap_en     = 1'b0;
  assign misaligned  = 1'b0;
`endif
  // Next state, latched opcode and wait counter; the counter only runs while waiting in FETCH/MEM
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (!wait_hit) cnt_d = cnt_q + CNT_W'(1);
      S_DECODE: begin
        op_d    = opcode;
        state_d = legal ? S_EXEC : S_FETCH;
      end
      S_EXEC:   state_d = (is_load || is_store) ? (misaligned ? S_TRAP : S_MEM) : S_WB;
      S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
                else if (wait_hit) state_d = S_FETCH;
                else cnt_d = cnt_q + CNT_W'(1);
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end
  // State registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  // Strobes decoded from state and latched opcode, forced low while reset is held
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 2'b00;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_size    = 2'b00;
    load_signed = 1'b0;
    illegal_op  = 1'b0;
    timeout     = 1'b0;
    trap        = 1'b0;
    state       = reset ? 3'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          mem_size = 2'b10;
          ir_write = mem_ready;
          pc_write = mem_ready;
          timeout  = wait_hit;
        end
        S_DECODE: illegal_op = !legal;
        S_EXEC:   alu_src = !is_r;
        S_MEM: begin
          mem_read    = is_load;
          mem_write   = is_store;
          mem_size    = mem_sz;
          load_signed = is_signed;
          timeout     = wait_hit;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load ? 2'b01 : is_lui ? 2'b10 : 2'b00;
        end
        S_TRAP:  trap = trap_en;
        default: ;
      endcase
    end
  end
endmodule
